// File: rtl/prefix_adder_bist.sv
// prefix_adder_bist: built-in self-test engine for a 32-bit combinational
// adder (Brent-Kung, Kogge-Stone, ...). It drives operand pairs onto
// dut_a/dut_b, samples dut_s one clock later and compares it with a
// behavioural A+B (33 bits, carry-out included).
//
// Ports:
//   clk, rst          single clock, synchronous active-high reset
//   start             one-cycle request; accepted in IDLE or DONE only
//   dut_a, dut_b      registered operands to the adder under test
//   dut_s             33-bit sum from the adder under test
//   busy              high while vectors are applied or the pipe drains
//   done, pass        end-of-run flag; pass = no mismatches (valid when done)
//   err_count         saturating mismatch count
//   first_a/b/s       operands and observed sum of the first mismatch
//
// Handshake: start is sampled on every rising edge; a run is accepted only
// when busy=0. done stays high until the next accepted start or rst.
// Outputs err_count/first_* are stable while done=1.
//
// Run timeline (N = 8 + PATTERNS): the start edge E0 loads vector 0; edge
// E_k loads vector k and checks vector k-1; E_N checks the last vector and
// enters DRAIN; E_{N+1} enters DONE.
module prefix_adder_bist #(
  parameter int          PATTERNS = 1024,
  parameter logic [31:0] SEED_A   = 32'hACE1_2468,
  parameter logic [31:0] SEED_B   = 32'h1357_BDF9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [31:0] dut_a,
  output logic [31:0] dut_b,
  input  logic [32:0] dut_s,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] err_count,
  output logic [31:0] first_a,
  output logic [31:0] first_b,
  output logic [32:0] first_s
);

  localparam logic [16:0] N = 17'(PATTERNS + 8);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [31:0] lfsr_a_q, lfsr_a_d, lfsr_b_q, lfsr_b_d;
  logic [16:0] idx_q, idx_d;      // index of the next vector to load
  logic        busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [15:0] err_q, err_d;
  logic [31:0] first_a_q, first_a_d, first_b_q, first_b_d;
  logic [32:0] first_s_q, first_s_d;
  logic [32:0] sum_exp;

  function automatic logic [31:0] lfsr_next(input logic [31:0] x);
    return {x[30:0], x[31] ^ x[21] ^ x[1] ^ x[0]};
  endfunction

  // Fixed corner vectors {A, B}: carry ripple, all-ones, alternating bits.
  function automatic logic [63:0] corner(input logic [2:0] k);
    logic [63:0] v;
    case (k)
      3'd0:    v = {32'h0000_0000, 32'h0000_0000};
      3'd1:    v = {32'hFFFF_FFFF, 32'h0000_0001};
      3'd2:    v = {32'hFFFF_FFFF, 32'hFFFF_FFFF};
      3'd3:    v = {32'h0000_0001, 32'hFFFF_FFFF};
      3'd4:    v = {32'h5555_5555, 32'hAAAA_AAAA};
      3'd5:    v = {32'hAAAA_AAAA, 32'h5555_5555};
      3'd6:    v = {32'h8000_0000, 32'h8000_0000};
      default: v = {32'hFFFF_FFFF, 32'h0000_0000};
    endcase
    return v;
  endfunction

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    lfsr_a_d  = lfsr_a_q;
    lfsr_b_d  = lfsr_b_q;
    idx_d     = idx_q;
    busy_d    = busy_q;
    done_d    = done_q;
    pass_d    = pass_q;
    err_d     = err_q;
    first_a_d = first_a_q;
    first_b_d = first_b_q;
    first_s_d = first_s_q;
    // a_q/b_q hold the vector the adder is currently seeing, so they are the
    // registered copy the reference sum is built from.
    sum_exp   = {1'b0, a_q} + {1'b0, b_q};

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d   = S_RUN;
          a_d       = 32'h0;
          b_d       = 32'h0;
          lfsr_a_d  = SEED_A;
          lfsr_b_d  = SEED_B;
          idx_d     = 17'd1;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          pass_d    = 1'b0;
          err_d     = 16'h0;
          first_a_d = 32'h0;
          first_b_d = 32'h0;
          first_s_d = 33'h0;
        end
      end
      S_RUN: begin
        if (dut_s != sum_exp) begin
          if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
          // The count never wraps, so zero means no mismatch yet this run.
          if (err_q == 16'h0) begin
            first_a_d = a_q;
            first_b_d = b_q;
            first_s_d = dut_s;
          end
        end
        if (idx_q == N) begin
          state_d = S_DRAIN;
          a_d     = 32'h0;
          b_d     = 32'h0;
        end else begin
          if (idx_q < 17'd8) begin
            {a_d, b_d} = corner(idx_q[2:0]);
          end else begin
            lfsr_a_d = lfsr_next(lfsr_a_q);
            lfsr_b_d = lfsr_next(lfsr_b_q);
            a_d      = lfsr_a_d;
            b_d      = lfsr_b_d;
          end
          idx_d = idx_q + 17'd1;
        end
      end
      S_DRAIN: begin
        state_d = S_DONE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        pass_d  = (err_q == 16'h0);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      a_q       <= 32'h0;
      b_q       <= 32'h0;
      lfsr_a_q  <= SEED_A;
      lfsr_b_q  <= SEED_B;
      idx_q     <= 17'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      err_q     <= 16'h0;
      first_a_q <= 32'h0;
      first_b_q <= 32'h0;
      first_s_q <= 33'h0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      lfsr_a_q  <= lfsr_a_d;
      lfsr_b_q  <= lfsr_b_d;
      idx_q     <= idx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      err_q     <= err_d;
      first_a_q <= first_a_d;
      first_b_q <= first_b_d;
      first_s_q <= first_s_d;
    end
  end

  assign dut_a     = a_q;
  assign dut_b     = b_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign first_a   = first_a_q;
  assign first_b   = first_b_q;
  assign first_s   = first_s_q;

endmodule

// File: tb/tb_prefix_adder_bist.sv
// Bench for prefix_adder_bist. Four engines share one clock, each wrapped
// around its own adder model:
//   u0 PATTERNS=4     correct adder (latency, vector stream, rst mid-run)
//   u1 PATTERNS=0     carry-out stuck at 0 (restart from DONE)
//   u2 PATTERNS=1024  sum bit 16 stuck at 1
//   u3 PATTERNS=65535 constant 0 output (err_count saturation)
// Drivers push expected end-of-run results (and u0's operand stream) into
// queues; monitors pop and compare when the engines present them.
module tb_prefix_adder_bist;

  localparam logic [31:0] SA = 32'hACE1_2468;
  localparam logic [31:0] SB = 32'h1357_BDF9;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        start [4];
  logic        rst   [4];
  logic [31:0] a     [4];
  logic [31:0] b     [4];
  logic [32:0] s     [4];
  logic        busy  [4];
  logic        done  [4];
  logic        pass_o[4];
  logic [15:0] err   [4];
  logic [31:0] fa    [4];
  logic [31:0] fb    [4];
  logic [32:0] fs    [4];

  // Adder models under test.
  logic [32:0] true0, true1, true2;
  assign true0 = {1'b0, a[0]} + {1'b0, b[0]};
  assign true1 = {1'b0, a[1]} + {1'b0, b[1]};
  assign true2 = {1'b0, a[2]} + {1'b0, b[2]};
  assign s[0]  = true0;
  assign s[1]  = {1'b0, true1[31:0]};
  assign s[2]  = true2 | 33'h0_0001_0000;
  assign s[3]  = 33'h0;

  prefix_adder_bist #(.PATTERNS(4)) u0 (
    .clk(clk), .rst(rst[0]), .start(start[0]), .dut_a(a[0]), .dut_b(b[0]),
    .dut_s(s[0]), .busy(busy[0]), .done(done[0]), .pass(pass_o[0]),
    .err_count(err[0]), .first_a(fa[0]), .first_b(fb[0]), .first_s(fs[0]));
  prefix_adder_bist #(.PATTERNS(0)) u1 (
    .clk(clk), .rst(rst[1]), .start(start[1]), .dut_a(a[1]), .dut_b(b[1]),
    .dut_s(s[1]), .busy(busy[1]), .done(done[1]), .pass(pass_o[1]),
    .err_count(err[1]), .first_a(fa[1]), .first_b(fb[1]), .first_s(fs[1]));
  prefix_adder_bist #(.PATTERNS(1024)) u2 (
    .clk(clk), .rst(rst[2]), .start(start[2]), .dut_a(a[2]), .dut_b(b[2]),
    .dut_s(s[2]), .busy(busy[2]), .done(done[2]), .pass(pass_o[2]),
    .err_count(err[2]), .first_a(fa[2]), .first_b(fb[2]), .first_s(fs[2]));
  prefix_adder_bist #(.PATTERNS(65535)) u3 (
    .clk(clk), .rst(rst[3]), .start(start[3]), .dut_a(a[3]), .dut_b(b[3]),
    .dut_s(s[3]), .busy(busy[3]), .done(done[3]), .pass(pass_o[3]),
    .err_count(err[3]), .first_a(fa[3]), .first_b(fb[3]), .first_s(fs[3]));

  // ---------------- scoreboard ----------------
  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Result record: {done_cycle[31:0], pass, err[15:0], fa[31:0], fb[31:0], fs[32:0]}
  logic [145:0] q_res0[$], q_res1[$], q_res2[$], q_res3[$];
  logic [63:0]  q_vec0[$];

  function automatic logic [145:0] rec(input int unsigned c, input logic p, input logic [15:0] e,
                                        input logic [31:0] xa, input logic [31:0] xb,
                                        input logic [32:0] xs);
    return {c, p, e, xa, xb, xs};
  endfunction

  task automatic push_res(input int i, input logic [145:0] r);
    case (i)
      0: q_res0.push_back(r);
      1: q_res1.push_back(r);
      2: q_res2.push_back(r);
      default: q_res3.push_back(r);
    endcase
  endtask

  task automatic pop_res(input int i, output logic ok, output logic [145:0] r);
    ok = 1'b0;
    r  = '0;
    case (i)
      0: if (q_res0.size() > 0) begin r = q_res0.pop_front(); ok = 1'b1; end
      1: if (q_res1.size() > 0) begin r = q_res1.pop_front(); ok = 1'b1; end
      2: if (q_res2.size() > 0) begin r = q_res2.pop_front(); ok = 1'b1; end
      default: if (q_res3.size() > 0) begin r = q_res3.pop_front(); ok = 1'b1; end
    endcase
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] nx(input logic [31:0] x);
    return {x[30:0], x[31] ^ x[21] ^ x[1] ^ x[0]};
  endfunction

  function automatic logic [63:0] corner_tb(input int k);
    case (k)
      0: return {32'h0000_0000, 32'h0000_0000};
      1: return {32'hFFFF_FFFF, 32'h0000_0001};
      2: return {32'hFFFF_FFFF, 32'hFFFF_FFFF};
      3: return {32'h0000_0001, 32'hFFFF_FFFF};
      4: return {32'h5555_5555, 32'hAAAA_AAAA};
      5: return {32'hAAAA_AAAA, 32'h5555_5555};
      6: return {32'h8000_0000, 32'h8000_0000};
      default: return {32'hFFFF_FFFF, 32'h0000_0000};
    endcase
  endfunction

  // Operand stream u0 must show while busy: N vectors then the drain zero.
  task automatic expect_vectors(input int p);
    logic [31:0] la, lb;
    la = SA;
    lb = SB;
    for (int k = 0; k < 8 + p; k++) begin
      if (k < 8) q_vec0.push_back(corner_tb(k));
      else begin
        la = nx(la);
        lb = nx(lb);
        q_vec0.push_back({la, lb});
      end
    end
    q_vec0.push_back(64'h0);
  endtask

  // Expected u2 result: a mismatch whenever the true sum has bit 16 clear.
  task automatic expect_bit16(input int unsigned t0);
    logic [31:0] la, lb, va, vb;
    logic [32:0] sm, fsx;
    logic [15:0] ec;
    logic [31:0] xa, xb;
    logic [32:0] xs;
    logic [63:0] v;
    la = SA; lb = SB; ec = 16'h0; xa = '0; xb = '0; xs = '0;
    for (int k = 0; k < 1032; k++) begin
      if (k < 8) begin
        v  = corner_tb(k);
        va = v[63:32];
        vb = v[31:0];
      end else begin
        la = nx(la);
        lb = nx(lb);
        va = la;
        vb = lb;
      end
      sm  = {1'b0, va} + {1'b0, vb};
      fsx = sm | 33'h0_0001_0000;
      if (fsx != sm) begin
        if (ec == 16'h0) begin xa = va; xb = vb; xs = fsx; end
        ec = ec + 16'd1;
      end
    end
    check("u2 model_nonzero_errors", 64'(ec != 16'h0), 64'd1);
    push_res(2, rec(t0 + 1033, ec == 16'h0, ec, xa, xb, xs));
  endtask

  // ---------------- monitors ----------------
  for (genvar g = 0; g < 4; g++) begin : g_mon
    logic done_prev = 1'b0;
    always @(negedge clk) begin
      logic         ok;
      logic [145:0] e;
      if (done[g] && !done_prev) begin
        pop_res(g, ok, e);
        if (!ok) check($sformatf("u%0d unexpected_done", g), 64'd1, 64'd0);
        else begin
          check($sformatf("u%0d done_cycle", g), 64'(cyc), 64'(e[145:114]));
          check($sformatf("u%0d pass", g), 64'(pass_o[g]), 64'(e[113]));
          check($sformatf("u%0d err_count", g), 64'(err[g]), 64'(e[112:97]));
          check($sformatf("u%0d first_a", g), 64'(fa[g]), 64'(e[96:65]));
          check($sformatf("u%0d first_b", g), 64'(fb[g]), 64'(e[64:33]));
          check($sformatf("u%0d first_s", g), 64'(fs[g]), 64'(e[32:0]));
        end
      end
      done_prev <= done[g];
    end
  end

  always @(negedge clk) begin
    logic [63:0] ev;
    if (busy[0]) begin
      if (q_vec0.size() == 0) check("u0 unexpected_vector", {a[0], b[0]}, 64'h0);
      else begin
        ev = q_vec0.pop_front();
        check("u0 operands", {a[0], b[0]}, ev);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_start(input int i, output int unsigned t0);
    @(posedge clk); #1 start[i] = 1'b1;
    @(posedge clk); #1 start[i] = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait_done(input int i, input int lim);
    for (int k = 0; k < lim; k++) begin
      if (done[i]) break;
      @(posedge clk); #1;
    end
    check($sformatf("u%0d done_within_bound", i), 64'(done[i]), 64'd1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int unsigned t0, t1, t2, t3;
    for (int i = 0; i < 4; i++) begin start[i] = 1'b0; rst[i] = 1'b1; end
    repeat (3) @(posedge clk);
    #1 for (int i = 0; i < 4; i++) rst[i] = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("u%0d reset busy", i), 64'(busy[i]), 64'd0);
      check($sformatf("u%0d reset done", i), 64'(done[i]), 64'd0);
      check($sformatf("u%0d reset pass", i), 64'(pass_o[i]), 64'd0);
      check($sformatf("u%0d reset err", i), 64'(err[i]), 64'd0);
      check($sformatf("u%0d reset dut_ab", i), {a[i], b[i]}, 64'h0);
      check($sformatf("u%0d reset first_s", i), 64'(fs[i]), 64'h0);
    end

    fork
      begin : drv0
        // Run 1: start pulses while busy must not disturb timing or results.
        pulse_start(0, t0);
        expect_vectors(4);
        push_res(0, rec(t0 + 13, 1'b1, 16'h0, 32'h0, 32'h0, 33'h0));
        @(posedge clk); #1 start[0] = 1'b1;
        @(posedge clk); #1 start[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1 start[0] = 1'b1;
        @(posedge clk); #1 start[0] = 1'b0;
        wait_done(0, 40);
        // Run 2: reset two cycles into the run.
        pulse_start(0, t0);
        expect_vectors(4);
        push_res(0, rec(t0 + 13, 1'b1, 16'h0, 32'h0, 32'h0, 33'h0));
        @(posedge clk);
        @(posedge clk); #1 rst[0] = 1'b1;
        @(posedge clk); #1 rst[0] = 1'b0;
        q_vec0.delete();
        q_res0.delete();
        @(negedge clk);
        check("u0 midrst busy", 64'(busy[0]), 64'd0);
        check("u0 midrst done", 64'(done[0]), 64'd0);
        check("u0 midrst dut_a", 64'(a[0]), 64'd0);
        check("u0 midrst err", 64'(err[0]), 64'd0);
        // Run 3: fresh start replays the identical vector sequence.
        pulse_start(0, t0);
        expect_vectors(4);
        push_res(0, rec(t0 + 13, 1'b1, 16'h0, 32'h0, 32'h0, 33'h0));
        wait_done(0, 40);
      end
      begin : drv1
        pulse_start(1, t1);
        push_res(1, rec(t1 + 9, 1'b0, 16'd4, 32'hFFFF_FFFF, 32'h0000_0001, 33'h0));
        wait_done(1, 40);
        repeat (2) @(posedge clk);
        // Restart from DONE: counters clear, same corners fail again.
        pulse_start(1, t1);
        check("u1 restart done_drops", 64'(done[1]), 64'd0);
        check("u1 restart busy", 64'(busy[1]), 64'd1);
        push_res(1, rec(t1 + 9, 1'b0, 16'd4, 32'hFFFF_FFFF, 32'h0000_0001, 33'h0));
        wait_done(1, 40);
      end
      begin : drv2
        pulse_start(2, t2);
        expect_bit16(t2);
        wait_done(2, 1100);
      end
      begin : drv3
        pulse_start(3, t3);
        push_res(3, rec(t3 + 65544, 1'b0, 16'hFFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33'h0));
        wait_done(3, 70000);
      end
    join

    @(negedge clk);
    @(negedge clk);
    check("leftover u0 results", 64'(q_res0.size()), 64'd0);
    check("leftover u1 results", 64'(q_res1.size()), 64'd0);
    check("leftover u2 results", 64'(q_res2.size()), 64'd0);
    check("leftover u3 results", 64'(q_res3.size()), 64'd0);
    check("leftover u0 vectors", 64'(q_vec0.size()), 64'd0);
    check("u3 err stable after done", 64'(err[3]), 64'hFFFF);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/prefix_adder_bist.md
Name: prefix_adder_bist

Overview:
On-FPGA built-in self-test engine for the 32-bit prefix adders (Brent-Kung, Kogge-Stone, etc.).
- Drives operands A/B into a combinational adder under test and samples its 33-bit sum one cycle later.
- Checks each sum against an internal behavioural A+B and reports pass/fail, error count and the first failing vector.
- Sits directly upstream and downstream of the adder: it feeds it and consumes its output, so hardware runs need no simulator.

Parameters:
PATTERNS, 1024, number of pseudo-random vectors after the corner phase; 0 to 65535 (0 = corners only)
SEED_A, 32'hACE1_2468, reset/start seed of LFSR A; must be nonzero
SEED_B, 32'h1357_BDF9, reset/start seed of LFSR B; must be nonzero

Ports:
clk  in  1  single clock, all state on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle request to begin a run
dut_a  out  32  operand A to adder under test (registered)
dut_b  out  32  operand B to adder under test (registered)
dut_s  in  33  sum from adder under test (combinational from dut_a/dut_b)
busy  out  1  high while vectors are being applied or drained
done  out  1  high from end of run until next start or rst
pass  out  1  valid when done; 1 iff err_count == 0
err_count  out  16  mismatches seen, saturating at 16'hFFFF
first_a  out  32  A of first mismatching vector
first_b  out  32  B of first mismatching vector
first_s  out  33  dut_s value of first mismatching vector

Behaviour:
- Reset (rst=1 at an edge, from any state, including mid-run): state=IDLE; dut_a=dut_b=0; busy=0, done=0, pass=0; err_count=0; first_a/first_b/first_s=0; LFSRs reload seeds; vector index=0.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: start=1 at edge E0 moves to RUN. Same edge loads vector 0 onto dut_a/dut_b, sets busy=1 and clears err/first registers.
- DONE: start=1 behaves exactly as in IDLE (restart); done drops at E0.
- start while busy is ignored.
- N = 8 + PATTERNS. Vector k is driven on dut_a/dut_b during the cycle following edge E_k, for k = 0..N-1.
- Vectors 0..7 are fixed corners (A,B):
  - (0,0)
  - (FFFFFFFF,1)
  - (FFFFFFFF,FFFFFFFF)
  - (1,FFFFFFFF)
  - (55555555,AAAAAAAA)
  - (AAAAAAAA,55555555)
  - (80000000,80000000)
  - (FFFFFFFF,0)
- Vectors 8..N-1 come from two 32-bit Fibonacci LFSRs, each shifted at the edge that loads it:
  - next = {lfsr[30:0], lfsr[31]^lfsr[21]^lfsr[1]^lfsr[0]}
  - Vector 8 equals the first shift of SEED_A / SEED_B.
- Check pipeline: at edge E_{k+1}, dut_s is compared against expected = {1'b0,A_k} + {1'b0,B_k}, computed from a registered copy of the vector; full 33-bit compare, carry-out included.
- Mismatch handling:
  - err_count increments unless it is already FFFF (saturate, no wrap).
  - If this is the first mismatch of the run, first_a/first_b/first_s capture A_k, B_k and dut_s.
- Edge E_N performs the last compare; state becomes DRAIN and dut_a/dut_b return to 0.
- Edge E_{N+1}: state DONE; busy=0, done=1, pass=(err_count==0).
- Latency from the start-sampling edge to done=1 is N+1 clocks (1033 at default).
- Outputs err_count and first_* are stable while done=1. During a run they update as described.
- The vector counter is 17 bits, so N up to 65543 never wraps.

Test Plan:
- Correct adder model, PATTERNS=4: pulse start → done=1 exactly 13 clocks after start edge; pass=1; err_count=0; dut_a sequence begins 0, FFFFFFFF, FFFFFFFF, 1, 55555555.
- Adder model with carry-out stuck at 0, PATTERNS=0: vectors 1,2,3,6 fail → err_count=4; pass=0; first_a=FFFFFFFF, first_b=1, first_s=0_00000000.
- Adder model with bit 16 of sum stuck at 1, PATTERNS=1024: err_count equals the bench's own count of affected vectors (nonzero); first_* matches the first such vector from the bench's LFSR model.
- Assert rst two cycles into a run: next cycle busy=0, done=0, dut_a=0, err_count=0; a fresh start reproduces the identical vector sequence.
- Start pulses while busy are ignored (done timing unchanged). Start in DONE restarts with err_count cleared and the same seeds.
- Adder model that always outputs 0, PATTERNS=65535: err_count saturates at FFFF and does not wrap; pass=0.
